// File: rtl/frame_mem_arbiter.sv
`timescale 1ns/1ps
// frame_mem_arbiter
// Shares the single external memory command port between the two camera write
// streams (wr0, wr1) and the display read stream (rd). Grants are bursts of up
// to MAX_BURST accepted transfers, ending early when the owner drops its request.
// Arbitration is round-robin wr0 -> wr1 -> rd. There is one ARB bubble cycle
// between consecutive grants.
//
// Optional feature macro: RD_PRIORITY_EN
//   When defined, a pending rd wins arbitration. The only exception is directly
//   after an rd grant while a writer is waiting, which keeps writers from
//   starving. Writers round-robin between themselves.
//
// Ports:
//   clk, reset             clock, synchronous active-low reset
//   wrN_en/addr/data       write requests (en active-low), wrN_rdy = accepted
//   rd_en/addr, rd_rdy     read command request (en active-low) and accept
//   rd_data, rd_data_valid read return, forwarded straight from memory
//   mem_*                  memory command port (strobes active-low)
//   gnt                    one-hot owner {rd, wr1, wr0}, 0 while arbitrating
module frame_mem_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 29,
    parameter int unsigned MAX_BURST  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr0_en,
    input  logic [ADDR_WIDTH-1:0] wr0_addr,
    input  logic [DATA_WIDTH-1:0] wr0_data,
    output logic                  wr0_rdy,
    input  logic                  wr1_en,
    input  logic [ADDR_WIDTH-1:0] wr1_addr,
    input  logic [DATA_WIDTH-1:0] wr1_data,
    output logic                  wr1_rdy,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_rdy,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rdy,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_rd_valid,
    output logic [2:0]            gnt
);

    typedef enum logic [1:0] {StArb, StGntWr0, StGntWr1, StGntRd} state_e;

    localparam logic [1:0]  OwnWr0    = 2'd0;
    localparam logic [1:0]  OwnWr1    = 2'd1;
    localparam logic [1:0]  OwnRd     = 2'd2;
    localparam logic [16:0] BurstLen  = 17'(MAX_BURST);

    state_e      state;
    logic [15:0] cnt;
    logic [1:0]  last;
`ifdef RD_PRIORITY_EN
    logic        rd_last;  // previous grant went to rd
`endif

    logic req_wr0, req_wr1, req_rd;
    assign req_wr0 = ~wr0_en;
    assign req_wr1 = ~wr1_en;
    assign req_rd  = ~rd_en;

    // Read return is independent of ownership so late reads still arrive.
    assign rd_data       = mem_rd_data;
    assign rd_data_valid = mem_rd_valid;

    // Arbitration winner among pending requests
    logic [1:0] win;
    logic       win_vld;
    always_comb begin
        win     = OwnWr0;
        win_vld = req_wr0 | req_wr1 | req_rd;
`ifdef RD_PRIORITY_EN
        if (req_rd && !(rd_last && (req_wr0 || req_wr1))) begin
            win = OwnRd;
        end else if (last == OwnWr0) begin
            win = req_wr1 ? OwnWr1 : OwnWr0;
        end else begin
            win = req_wr0 ? OwnWr0 : OwnWr1;
        end
`else
        case (last)
            OwnWr0:  win = req_wr1 ? OwnWr1 : (req_rd  ? OwnRd  : OwnWr0);
            OwnWr1:  win = req_rd  ? OwnRd  : (req_wr0 ? OwnWr0 : OwnWr1);
            default: win = req_wr0 ? OwnWr0 : (req_wr1 ? OwnWr1 : OwnRd);
        endcase
`endif
    end

    // Current owner's request and index
    logic       own_req;
    logic [1:0] own_idx;
    always_comb begin
        own_req = 1'b0;
        own_idx = OwnWr0;
        unique case (state)
            StGntWr0: begin own_req = req_wr0; own_idx = OwnWr0; end
            StGntWr1: begin own_req = req_wr1; own_idx = OwnWr1; end
            StGntRd:  begin own_req = req_rd;  own_idx = OwnRd;  end
            default:  ;
        endcase
    end

    logic accept, burst_done;
    assign accept     = own_req & mem_rdy;
    assign burst_done = accept && (({1'b0, cnt} + 17'd1) == BurstLen);

    // Command port mux; idle values while arbitrating
    always_comb begin
        mem_wr_en = 1'b1;
        mem_rd_en = 1'b1;
        mem_addr  = '0;
        mem_wdata = '0;
        wr0_rdy   = 1'b0;
        wr1_rdy   = 1'b0;
        rd_rdy    = 1'b0;
        unique case (state)
            StGntWr0: begin
                mem_wr_en = wr0_en;
                mem_addr  = wr0_addr;
                mem_wdata = wr0_data;
                wr0_rdy   = req_wr0 & mem_rdy;
            end
            StGntWr1: begin
                mem_wr_en = wr1_en;
                mem_addr  = wr1_addr;
                mem_wdata = wr1_data;
                wr1_rdy   = req_wr1 & mem_rdy;
            end
            StGntRd: begin
                mem_rd_en = rd_en;
                mem_addr  = rd_addr;
                rd_rdy    = req_rd & mem_rdy;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= StArb;
            gnt     <= '0;
            cnt     <= '0;
            last    <= OwnRd;
`ifdef RD_PRIORITY_EN
            rd_last <= 1'b0;
`endif
        end else begin
            if (state == StArb) begin
                if (win_vld) begin
                    cnt <= '0;
                    case (win)
                        OwnWr0:  begin state <= StGntWr0; gnt <= 3'b001; end
                        OwnWr1:  begin state <= StGntWr1; gnt <= 3'b010; end
                        default: begin state <= StGntRd;  gnt <= 3'b100; end
                    endcase
                end
            end else begin
                if (accept) begin
                    cnt <= cnt + 16'd1;
                end
                // Count limit and request drop can coincide; one exit either way.
                if (burst_done || !own_req) begin
                    state <= StArb;
                    gnt   <= '0;
`ifdef RD_PRIORITY_EN
                    if (state == StGntRd) begin
                        rd_last <= 1'b1;
                    end else begin
                        rd_last <= 1'b0;
                        last    <= own_idx;
                    end
`else
                    last  <= own_idx;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_mem_arbiter.sv
`timescale 1ns/1ps
module tb_frame_mem_arbiter;

    localparam int AW = 29;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr0_en, wr1_en, rd_en, mem_rdy, mem_rd_valid;
    logic [AW-1:0] wr0_addr, wr1_addr, rd_addr;
    logic [DW-1:0] wr0_data, wr1_data, mem_rd_data;

    logic          wr0_rdy, wr1_rdy, rd_rdy, rd_data_valid, mem_wr_en, mem_rd_en;
    logic [DW-1:0] rd_data, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [2:0]    gnt;

    logic          b1_wr0_rdy, b1_wr1_rdy, b1_rd_rdy, b1_rd_data_valid;
    logic          b1_mem_wr_en, b1_mem_rd_en;
    logic [DW-1:0] b1_rd_data, b1_mem_wdata;
    logic [AW-1:0] b1_mem_addr;
    logic [2:0]    b1_gnt;

    always #5 clk = ~clk;

    frame_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(4)) u_dut (
        .clk(clk), .reset(reset),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_rdy(wr0_rdy),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_rdy(wr1_rdy),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdy(mem_rdy), .mem_rd_data(mem_rd_data),
        .mem_rd_valid(mem_rd_valid), .gnt(gnt)
    );

    // Second instance with single-transfer grants, sharing the stimulus
    frame_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(1)) u_b1 (
        .clk(clk), .reset(reset),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_rdy(b1_wr0_rdy),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_rdy(b1_wr1_rdy),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_rdy(b1_rd_rdy),
        .rd_data(b1_rd_data), .rd_data_valid(b1_rd_data_valid),
        .mem_wr_en(b1_mem_wr_en), .mem_rd_en(b1_mem_rd_en), .mem_addr(b1_mem_addr),
        .mem_wdata(b1_mem_wdata), .mem_rdy(mem_rdy), .mem_rd_data(mem_rd_data),
        .mem_rd_valid(mem_rd_valid), .gnt(b1_gnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int w, input int i);
        logic [31:0] a;
        a = 32'h0010_0000 * 32'(w + 1) + 32'(i);
        return AW'(a);
    endfunction

    function automatic logic [DW-1:0] data_of(input int w, input int i);
        logic [31:0] d;
        d = 32'hA500_0000 + 32'(w) * 32'h0001_0000 + 32'(i);
        return DW'(d);
    endfunction

    // n-th grant owner (0=wr0, 1=wr1, 2=rd) when all three request continuously
    function automatic int owner_of(input int n);
`ifdef RD_PRIORITY_EN
        case (n % 4)
            1:       return 0;
            3:       return 1;
            default: return 2;
        endcase
`else
        return n % 3;
`endif
    endfunction

    // Scoreboards
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    wr_t           wr_q[$];
    logic [DW-1:0] rd_q[$];
    bit            sb_on = 1'b0;

    always @(negedge clk) begin
        wr_t e;
        if (sb_on && !mem_wr_en && mem_rdy) begin
            if (wr_q.size() == 0) begin
                chk("write_expected", 64'(wr_q.size() != 0), 64'd1);
            end else begin
                e = wr_q.pop_front();
                chk("write_addr", 64'(mem_addr), 64'(e.addr));
                chk("write_data", 64'(mem_wdata), 64'(e.data));
            end
        end
        if (rd_data_valid) begin
            if (rd_q.size() == 0) begin
                chk("read_expected", 64'(rd_q.size() != 0), 64'd1);
            end else begin
                chk("read_data", 64'(rd_data), 64'(rd_q.pop_front()));
            end
        end
    end

    task automatic set_writer(input int w, input logic en, input int k);
        if (w == 0) begin
            wr0_en = en; wr0_addr = addr_of(0, k); wr0_data = data_of(0, k);
        end else begin
            wr1_en = en; wr1_addr = addr_of(1, k); wr1_data = data_of(1, k);
        end
    endtask

    // One writer requests n transfers; mem_rdy is held low for stall_len cycles
    // once stall_after transfers have been accepted.
    task automatic wr_burst(input int w, input int n, input int stall_after, input int stall_len);
        int   k = 0;
        int   stalled = 0;
        int   guard = 0;
        logic acc;
        for (int i = 0; i < n; i++) wr_q.push_back('{addr: addr_of(w, i), data: data_of(w, i)});
        set_writer(w, 1'b0, 0);
        while (k < n && guard < 200) begin
            mem_rdy = !(k == stall_after && stalled < stall_len);
            @(negedge clk);
            acc = (w == 0) ? wr0_rdy : wr1_rdy;
            if (!mem_rdy) begin
                stalled++;
                chk("stall_rdy", 64'(acc), 64'd0);
                chk("stall_gnt", 64'(gnt), 64'(3'b001 << w));
            end
            @(posedge clk); #1;
            if (acc) begin
                k++;
                set_writer(w, 1'b0, k);
            end
            guard++;
        end
        chk("burst_transfers", 64'(k), 64'(n));
        set_writer(w, 1'b1, k);
        mem_rdy = 1'b1;
    endtask

    typedef struct {
        logic [2:0]    req_n;      // {rd_en, wr1_en, wr0_en}
        logic          rdy_in;
        logic [2:0]    gnt;
        logic          wr_n;
        logic          rd_n;
        logic [2:0]    rdy;        // {rd_rdy, wr1_rdy, wr0_rdy}
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [2:0]    gnt1;       // MAX_BURST = 1 instance
    } vec_t;
    vec_t tbl[20];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 20; i++) begin
            int o;
            tbl[i].req_n  = 3'b000;
            tbl[i].rdy_in = 1'b1;
            if (i % 5 == 0) begin
                tbl[i].gnt = 3'b000; tbl[i].wr_n = 1'b1; tbl[i].rd_n = 1'b1;
                tbl[i].rdy = 3'b000; tbl[i].addr = '0;   tbl[i].wdata = '0;
            end else begin
                o = owner_of(i / 5);
                tbl[i].gnt   = 3'(3'b001 << o);
                tbl[i].wr_n  = (o == 2);
                tbl[i].rd_n  = (o != 2);
                tbl[i].rdy   = tbl[i].gnt;
                tbl[i].addr  = addr_of(o, 0);
                tbl[i].wdata = (o == 2) ? '0 : data_of(o, 0);
            end
            tbl[i].gnt1 = (i % 2 == 0) ? 3'b000 : 3'(3'b001 << owner_of(i / 2));
        end

        reset = 1'b0;
        wr0_en = 1'b1; wr1_en = 1'b1; rd_en = 1'b1; mem_rdy = 1'b1;
        mem_rd_valid = 1'b0; mem_rd_data = '0;
        wr0_addr = addr_of(0, 0); wr0_data = data_of(0, 0);
        wr1_addr = addr_of(1, 0); wr1_data = data_of(1, 0);
        rd_addr  = addr_of(2, 0);

        // Reset state, with read data forwarded while in reset
        @(posedge clk); #1;
        mem_rd_valid = 1'b1; mem_rd_data = 32'hCAFE_0001; rd_q.push_back(32'hCAFE_0001);
        @(negedge clk);
        chk("reset_gnt", 64'(gnt), 64'd0);
        chk("reset_gnt_b1", 64'(b1_gnt), 64'd0);
        chk("reset_strobes", 64'({mem_wr_en, mem_rd_en}), 64'b11);
        chk("reset_addr", 64'(mem_addr), 64'd0);
        chk("reset_rdy", 64'({rd_rdy, wr1_rdy, wr0_rdy}), 64'd0);
        @(posedge clk); #1;
        mem_rd_valid = 1'b0;

        // All requesting continuously: grant order, burst length, one-cycle bubble
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            {rd_en, wr1_en, wr0_en} = tbl[i].req_n;
            mem_rdy = tbl[i].rdy_in;
            @(negedge clk);
            chk($sformatf("rr_gnt[%0d]", i), 64'(gnt), 64'(tbl[i].gnt));
            chk($sformatf("rr_strobes[%0d]", i), 64'({mem_wr_en, mem_rd_en}),
                64'({tbl[i].wr_n, tbl[i].rd_n}));
            chk($sformatf("rr_rdy[%0d]", i), 64'({rd_rdy, wr1_rdy, wr0_rdy}), 64'(tbl[i].rdy));
            chk($sformatf("rr_addr[%0d]", i), 64'(mem_addr), 64'(tbl[i].addr));
            chk($sformatf("rr_wdata[%0d]", i), 64'(mem_wdata), 64'(tbl[i].wdata));
            chk($sformatf("b1_gnt[%0d]", i), 64'(b1_gnt), 64'(tbl[i].gnt1));
            @(posedge clk); #1;
        end
        {rd_en, wr1_en, wr0_en} = 3'b111;
        repeat (2) @(posedge clk); #1;

        // wr0 alone, drops its request after 3 transfers
        sb_on = 1'b1;
        wr_burst(0, 3, -1, 0);
        @(negedge clk);
        chk("drop_gnt_held", 64'(gnt), 64'b001);
        chk("drop_no_cmd", 64'(mem_wr_en), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drop_arb_gnt", 64'(gnt), 64'd0);
        chk("drop_wr_q_empty", 64'(wr_q.size()), 64'd0);
        @(posedge clk); #1;

        // wr1 stalled for 10 cycles after 2 transfers, then completes its burst of 4
        wr_burst(1, 4, 2, 10);
        @(negedge clk);
        chk("stall_burst_end_gnt", 64'(gnt), 64'd0);
        chk("stall_wr_q_empty", 64'(wr_q.size()), 64'd0);
        @(posedge clk); #1;

        // rd grant of 4 reads, then returns arrive during a wr0 grant
        rd_en = 1'b0;
        @(negedge clk);
        chk("rd_arb_cycle", 64'(gnt), 64'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rd_gnt[%0d]", i), 64'(gnt), 64'b100);
            chk($sformatf("rd_cmd[%0d]", i), 64'({mem_wr_en, mem_rd_en, rd_rdy}), 64'b101);
            chk($sformatf("rd_addr[%0d]", i), 64'(mem_addr), 64'(addr_of(2, 0)));
            @(posedge clk); #1;
        end
        rd_en = 1'b1;
        @(negedge clk);
        chk("rd_burst_end_gnt", 64'(gnt), 64'd0);
        @(posedge clk); #1;
        fork
            wr_burst(0, 4, -1, 0);
            begin
                for (int i = 0; i < 4; i++) begin
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = 32'hD00D_0000 + 32'(i);
                    rd_q.push_back(32'hD00D_0000 + 32'(i));
                    @(posedge clk); #1;
                    mem_rd_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
        join
        chk("late_reads_delivered", 64'(rd_q.size()), 64'd0);
        chk("late_wr_q_empty", 64'(wr_q.size()), 64'd0);
        sb_on = 1'b0;
        @(posedge clk); #1;

        // Reset asserted mid-burst in GNT_WR0
        wr0_en = 1'b0;
        repeat (2) @(posedge clk); #1;
        @(negedge clk);
        chk("pre_reset_gnt", 64'(gnt), 64'b001);
        @(posedge clk); #1;
        reset = 1'b0; wr1_en = 1'b0; rd_en = 1'b0;
        mem_rd_valid = 1'b1; mem_rd_data = 32'hBEEF_0002; rd_q.push_back(32'hBEEF_0002);
        @(posedge clk); #1;
        reset = 1'b1; mem_rd_valid = 1'b0;
        @(negedge clk);
        chk("mid_reset_gnt", 64'(gnt), 64'd0);
        chk("mid_reset_strobes", 64'({mem_wr_en, mem_rd_en}), 64'b11);
        chk("mid_reset_rdy", 64'({rd_rdy, wr1_rdy, wr0_rdy}), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
`ifdef RD_PRIORITY_EN
        chk("first_after_reset", 64'(gnt), 64'b100);
`else
        chk("first_after_reset", 64'(gnt), 64'b001);
`endif
        {rd_en, wr1_en, wr0_en} = 3'b111;
        repeat (2) @(posedge clk); #1;
        chk("rd_q_empty", 64'(rd_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
